sram_ws_wrapper: RTL and testbench

//  Bridges the L2 cache's 768-bit line-wide Wishbone port to the 48-bit word port of the SRAM controller.
//  A line is 16 words of 48 bits: bits 31:0 are data, bits 47:32 are tag/status.
//  One request runs 16 sequential word accesses.
//  The block then returns the whole line with a single ack pulse.

---
 rtl/sram_ws_wrapper.sv | 134 +++++++++++++
 tb/tb_sram_ws_wrapper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ws_wrapper.sv
// Line-wide Wishbone to word-wide SRAM controller bridge: one request becomes a 16-word burst, then a single ack.
// Optional macro SRAM_WS_SKIP_MASKED_EN: on writes, words with an all-zero byte mask are skipped.
module sram_ws_wrapper #(
   parameter int unsigned WORDS  = 16,
   parameter int unsigned WORD_W = 48,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                      clkCPU,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         ws_addr,
   input  logic [WORDS*WORD_W-1:0]   ws_din,
   input  logic [WORDS*WORD_W/8-1:0] ws_dm,
   input  logic                      ws_stb,
   input  logic                      ws_we,
   output logic                      ws_ack,
   output logic [WORDS*WORD_W-1:0]   ws_dout,
   input  logic [WORD_W-1:0]         sramOutData,
   output logic [ADDR_W-1:0]         sramAddr,
   output logic [WORD_W-1:0]         sramInData,
   output logic [WORD_W/8-1:0]       sramDm,
   output logic                      sramStb,
   input  logic                      sramNak
);

   localparam int unsigned IDX_W  = $clog2(WORDS);
   localparam int unsigned BE_W   = WORD_W / 8;
   localparam int unsigned LINE_W = WORDS * WORD_W;
   localparam int unsigned DM_W   = WORDS * BE_W;
   localparam int unsigned OFF_W  = IDX_W + 2;
   localparam int unsigned TAG_W  = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TAG_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]  din_q, din_d;
   logic [DM_W-1:0]    dm_q, dm_d;
   logic               we_q, we_d;
   logic [LINE_W-1:0]  dout_q, dout_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^ws_addr[OFF_W-1:0];

`ifdef SRAM_WS_SKIP_MASKED_EN
   // First word at or after start with a non-zero mask; MSB set when none is left.
   function automatic logic [IDX_W:0] next_word(input logic [DM_W-1:0] dm, input logic [IDX_W:0] start);
      logic [IDX_W:0] r;
      r = (IDX_W+1)'(WORDS);
      for (int i = WORDS - 1; i >= 0; i--) begin
         if ((IDX_W+1)'(i) >= start && dm[i*BE_W +: BE_W] != '0) r = (IDX_W+1)'(i);
      end
      return r;
   endfunction
   logic [IDX_W:0] nxt_c;
`endif

   always_ff @(posedge clkCPU or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         line_q  <= '0;
         din_q   <= '0;
         dm_q    <= '0;
         we_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         line_q  <= line_d;
         din_q   <= din_d;
         dm_q    <= dm_d;
         we_q    <= we_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      line_d  = line_q;
      din_d   = din_q;
      dm_d    = dm_q;
      we_d    = we_q;
      dout_d  = dout_q;
`ifdef SRAM_WS_SKIP_MASKED_EN
      nxt_c   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (ws_stb) begin
               line_d  = ws_addr[ADDR_W-1:OFF_W];
               din_d   = ws_din;
               dm_d    = ws_dm;
               we_d    = ws_we;
               idx_d   = '0;
               state_d = BUSY;
`ifdef SRAM_WS_SKIP_MASKED_EN
               if (ws_we) begin
                  nxt_c = next_word(ws_dm, '0);
                  if (nxt_c[IDX_W]) state_d = ACK;
                  else              idx_d   = nxt_c[IDX_W-1:0];
               end
`endif
            end
         end
         BUSY: begin
            // A word completes on any edge the controller does not nak.
            if (!sramNak) begin
               if (!we_q) dout_d[idx_q*WORD_W +: WORD_W] = sramOutData;
`ifdef SRAM_WS_SKIP_MASKED_EN
               if (we_q) begin
                  nxt_c = next_word(dm_q, {1'b0, idx_q} + (IDX_W+1)'(1));
                  if (nxt_c[IDX_W]) state_d = ACK;
                  else              idx_d   = nxt_c[IDX_W-1:0];
               end else
`endif
               if (idx_q == IDX_W'(WORDS - 1)) state_d = ACK;
               else                            idx_d   = idx_q + IDX_W'(1);
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ws_ack     = (state_q == ACK);
   assign sramStb    = (state_q == BUSY);
   assign ws_dout    = dout_q;
   assign sramAddr   = {line_q, idx_q, 2'b00};
   assign sramInData = din_q[idx_q*WORD_W +: WORD_W];
   assign sramDm     = (state_q == BUSY && we_q) ? dm_q[idx_q*BE_W +: BE_W] : '0;

endmodule

// File: tb/tb_sram_ws_wrapper.sv
// Directed bench for sram_ws_wrapper: SRAM word model with nak injection and an access log.
module tb_sram_ws_wrapper;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  ws_addr = '0;
   logic [767:0] ws_din = '0;
   logic [95:0]  ws_dm = '0;
   logic         ws_stb = 1'b0;
   logic         ws_we = 1'b0;
   logic         ws_ack;
   logic [767:0] ws_dout;
   logic [47:0]  sramOutData = '0;
   logic [31:0]  sramAddr;
   logic [47:0]  sramInData;
   logic [5:0]   sramDm;
   logic         sramStb;
   logic         sramNak = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] acc_addr[$];
   logic [5:0]  acc_dm[$];
   logic [47:0] acc_data[$];
   logic [31:0] nak_addr = 32'hFFFF_FFFF;
   int          nak_left = 0;
   int          nak_word_cyc = 0;

   sram_ws_wrapper dut (
      .clkCPU(clk), .rst(rst), .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
      .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack), .ws_dout(ws_dout),
      .sramOutData(sramOutData), .sramAddr(sramAddr), .sramInData(sramInData),
      .sramDm(sramDm), .sramStb(sramStb), .sramNak(sramNak)
   );

   always #5 clk = ~clk;

   // Controller model: optional nak on one address, log every accepted word.
   always @(negedge clk) begin
      if (sramStb && sramAddr == nak_addr && nak_left > 0) begin
         sramNak = 1'b1;
         nak_left--;
      end else begin
         sramNak = 1'b0;
      end
      if (sramStb && sramAddr == nak_addr) nak_word_cyc++;
      if (sramStb && !sramNak) begin
         acc_addr.push_back(sramAddr);
         acc_dm.push_back(sramDm);
         acc_data.push_back(sramInData);
      end
   end

   task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request; cyc is the ack cycle counted with the strobe cycle as cycle 1.
   task automatic run_burst(input logic [31:0] a, input logic we, input logic [767:0] din,
                            input logic [95:0] dm, output int cyc);
      int n;
      @(negedge clk);
      acc_addr.delete(); acc_dm.delete(); acc_data.delete();
      nak_word_cyc = 0;
      ws_addr = a; ws_we = we; ws_din = din; ws_dm = dm; ws_stb = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (ws_ack) break;
      end
      if (!ws_ack) check("ack_timeout", 1'b1, 1'b0);
      else         check("stb_low_in_ack", sramStb, 1'b0);
      cyc = n + 1;
      ws_stb = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", ws_ack, 1'b0);
   endtask

   logic [767:0] line;
   logic [767:0] rd_line;
   logic [95:0]  dm;
   int           cyc;
   int           acks;
   int           gap;
   logic [5:0]   dm_or;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ack", ws_ack, 1'b0);
      check("rst_stb", sramStb, 1'b0);
      check("rst_dm", sramDm, 6'h0);
      check("rst_dout", ws_dout, '0);
      rst = 1'b1;

      // Read burst, zero nak.
      sramOutData = 48'h0001_1234_5678;
      run_burst(32'h003F_FFC0, 1'b0, '0, '0, cyc);
      check("rd_latency", 32'(cyc), 32'd18);
      check("rd_nacc", 32'(acc_addr.size()), 32'd16);
      dm_or = '0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("rd_addr%0d", i), acc_addr[i], 32'h003F_FFC0 + 32'(4 * i));
         dm_or |= acc_dm[i];
      end
      check("rd_dm_zero", dm_or, 6'h0);
      rd_line = {16{48'h0001_1234_5678}};
      check("rd_dout", ws_dout, rd_line);

      // Write burst, full mask.
      for (int i = 0; i < 16; i++) line[i*48 +: 48] = {16'(i), 32'h8765_4321};
      run_burst(32'h0000_2000, 1'b1, line, '1, cyc);
      check("wr_latency", 32'(cyc), 32'd18);
      check("wr_nacc", 32'(acc_addr.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("wr_dm%0d", i), acc_dm[i], 6'h3F);
         check($sformatf("wr_data%0d", i), acc_data[i], {16'(i), 32'h8765_4321});
      end
      check("wr_dout_kept", ws_dout, rd_line);

      // Read with three nak cycles on word 5.
      sramOutData = 48'hABCD_00C0_FFEE;
      nak_addr = 32'h0000_0114;
      nak_left = 3;
      run_burst(32'h0000_0100, 1'b0, '0, '0, cyc);
      check("nak_latency", 32'(cyc), 32'd21);
      check("nak_word5_cycles", 32'(nak_word_cyc), 32'd4);
      check("nak_nacc", 32'(acc_addr.size()), 32'd16);
      check("nak_acc5", acc_addr[5], 32'h0000_0114);
      check("nak_dout", ws_dout, {16{48'hABCD_00C0_FFEE}});
      nak_addr = 32'hFFFF_FFFF;

      // Back-to-back clear loop, strobe held, address stepped on ack.
      @(negedge clk);
      acc_addr.delete(); acc_dm.delete(); acc_data.delete();
      ws_addr = 32'h0; ws_we = 1'b1; ws_din = '0; ws_dm = '1; ws_stb = 1'b1;
      cyc = 0; acks = 0; gap = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ws_ack) begin
            acks++;
            check($sformatf("b2b_stb_low_ack%0d", acks), sramStb, 1'b0);
            if (acks == 1) begin
               gap = cyc;
               ws_addr = 32'h40;
            end else break;
         end
      end
      ws_stb = 1'b0;
      check("b2b_acks", 32'(acks), 32'd2);
      check("b2b_gap", 32'(cyc - gap), 32'd18);
      check("b2b_nacc", 32'(acc_addr.size()), 32'd32);
      check("b2b_first", acc_addr[0], 32'h0);
      check("b2b_last1", acc_addr[15], 32'h3C);
      check("b2b_first2", acc_addr[16], 32'h40);
      check("b2b_last2", acc_addr[31], 32'h7C);
      check("b2b_data", acc_data[20], 48'h0);
      repeat (2) @(negedge clk);

      // Write with only word 0 enabled.
      dm = '0;
      dm[5:0] = 6'h3F;
      run_burst(32'h0000_0800, 1'b1, line, dm, cyc);
`ifdef SRAM_WS_SKIP_MASKED_EN
      check("mask_latency", 32'(cyc), 32'd3);
      check("mask_nacc", 32'(acc_addr.size()), 32'd1);
      check("mask_addr0", acc_addr[0], 32'h0000_0800);
      check("mask_dm0", acc_dm[0], 6'h3F);
`else
      check("mask_latency", 32'(cyc), 32'd18);
      check("mask_nacc", 32'(acc_addr.size()), 32'd16);
      check("mask_dm0", acc_dm[0], 6'h3F);
      dm_or = '0;
      for (int i = 1; i < 16; i++) dm_or |= acc_dm[i];
      check("mask_dm_rest", dm_or, 6'h0);
      check("mask_addr15", acc_addr[15], 32'h0000_083C);
`endif

      // Reset mid-burst, then a fresh request.
      @(negedge clk);
      ws_addr = 32'h0000_0400; ws_we = 1'b0; ws_stb = 1'b1;
      repeat (6) @(negedge clk);
      check("pre_rst_busy", sramStb, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_mid_stb", sramStb, 1'b0);
      check("rst_mid_ack", ws_ack, 1'b0);
      check("rst_mid_dout", ws_dout, '0);
      ws_stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      sramOutData = 48'h0000_5A5A_5A5A;
      run_burst(32'h0000_1000, 1'b0, '0, '0, cyc);
      check("post_rst_latency", 32'(cyc), 32'd18);
      check("post_rst_first", acc_addr[0], 32'h0000_1000);
      check("post_rst_dout", ws_dout, {16{48'h0000_5A5A_5A5A}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
